// File: rtl/lsu_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Brief    : Single-port data-memory bus between the LSU and data memory.
//            Valid/ready handshake, word address, byte strobes, and 32-bit
//            read and write data.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // The LSU drives the request side.
  modport master (
    output mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  // Memory drives the response side.
  modport slave (
    input  mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : Load/store unit. Sizes and aligns one access from the ALU's
//            effective address, runs a single valid/ready bus beat with a
//            timeout, and returns the extended load data with a done pulse.
// Revision : 1.0  initial release
// ============================================================================
module lsu #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  lsu_if.master       bus
);

  // The counter only needs to reach TIMEOUT-1; the beat expires on the
  // following stalled cycle.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            misaligned_q, misaligned_d;
  logic            bus_error_q, bus_error_d;
  logic [31:0]     load_data_q, load_data_d;
  logic            mem_valid_q, mem_valid_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            w_legal;
  logic            w_aligned;
  logic [3:0]      w_strb;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rshift;
  logic [31:0]     w_ext;
  logic            w_expired;

  // Decode the incoming request: legal width for the direction, natural alignment.
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !is_store;
      default:                w_legal = 1'b0;
    endcase
    if (funct3[0])      w_aligned = !addr[0];
    else if (funct3[1]) w_aligned = (addr[1:0] == 2'b00);
    else                w_aligned = 1'b1;
  end

  // Place store data into byte lanes according to width and offset.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << addr[1:0];
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  // Extract and extend the addressed byte/half/word from the read beat.
  always_comb begin
    w_rshift = bus.mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  w_ext = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'b001:  w_ext = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'b100:  w_ext = {24'd0, w_rshift[7:0]};
      3'b101:  w_ext = {16'd0, w_rshift[15:0]};
      default: w_ext = w_rshift;
    endcase
  end

  assign w_expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    load_data_d  = load_data_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        load_data_d = '0;
        if (start) begin
          funct3_d = funct3;
          off_d    = addr[1:0];
          if (w_legal && w_aligned) begin
            state_d     = S_REQ;
            busy_d      = 1'b1;
            mem_valid_d = 1'b1;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_we_d    = is_store;
            mem_wstrb_d = is_store ? w_strb : 4'b0000;
            mem_wdata_d = is_store ? w_wdata : 32'd0;
            cnt_d       = '0;
          end else begin
            state_d      = S_FAULT;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_ready) begin
          state_d     = S_RESP;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          mem_valid_d = 1'b0;
          load_data_d = mem_we_q ? 32'd0 : w_ext;
        end else if (w_expired) begin
          state_d     = S_RESP;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          bus_error_d = 1'b1;
          mem_valid_d = 1'b0;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // RESP and FAULT last one cycle; any start seen here is dropped.
        state_d     = S_IDLE;
        load_data_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      load_data_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      load_data_q  <= load_data_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign misaligned    = misaligned_q;
  assign bus_error     = bus_error_q;
  assign load_data     = load_data_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Brief    : Self-checking bench for lsu. Directed vectors plus randomized
//            accesses compared against a byte-lane arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu;
  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_if mif ();

  lsu #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .bus        (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int model_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic model_ok(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz = model_size(f3);
    if (sz == 0) return 1'b0;
    if (st && f3 >= 3'd4) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int sz = model_size(f3);
    int off = int'(a % 4);
    longint v;
    longint span;
    span = longint'(1) << (8 * sz);
    v = (longint'(rd) / (longint'(1) << (8 * off))) % span;
    if (f3 < 3'd4 && sz < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int sz = model_size(f3);
    int off = int'(a % 4);
    logic [3:0] s = 4'b0000;
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + sz);
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz = model_size(f3);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  // ---------------- bus driver: runs one access, reports what it saw ----------------
  task automatic run_access(
    input  logic        st,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] sd,
    input  logic [31:0] rd,
    input  int          wait_n,
    output int          lat,
    output int          vcnt,
    output logic [31:0] o_addr,
    output logic        o_we,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld,
    output logic        o_mis,
    output logic        o_berr,
    output logic        proto_ok
  );
    lat = -1; vcnt = 0; o_addr = '0; o_we = 1'b0; o_wstrb = '0; o_wdata = '0;
    o_ld = '0; o_mis = 1'b0; o_berr = 1'b0; proto_ok = 1'b1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    mif.mem_ready = 1'b0; mif.mem_rdata = rd;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      if ((misaligned || bus_error) && !done) proto_ok = 1'b0;
      if (done) begin
        if (busy || mif.mem_valid) proto_ok = 1'b0;
        lat = c; o_ld = load_data; o_mis = misaligned; o_berr = bus_error;
        mif.mem_ready = 1'b0;
        break;
      end
      if (!busy) proto_ok = 1'b0;
      if (mif.mem_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          o_addr = mif.mem_addr; o_we = mif.mem_we; o_wstrb = mif.mem_wstrb; o_wdata = mif.mem_wdata;
        end else if (mif.mem_addr !== o_addr || mif.mem_wstrb !== o_wstrb || mif.mem_wdata !== o_wdata) begin
          proto_ok = 1'b0;
        end
        mif.mem_ready = (vcnt > wait_n);
      end else begin
        mif.mem_ready = 1'b0;
      end
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    tick(); tick();
    n_tests++;
    if ({busy, done, misaligned, bus_error, mif.mem_valid, mif.mem_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=000000", {busy, done, misaligned, bus_error, mif.mem_valid, mif.mem_we});
    end
    n_tests++;
    if ({mif.mem_wstrb, mif.mem_addr, mif.mem_wdata, load_data} !== 100'd0) begin
      n_fail++;
      $display("FAIL reset_data got wstrb=%b addr=%h wdata=%h ld=%h exp all 0",
               mif.mem_wstrb, mif.mem_addr, mif.mem_wdata, load_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    int lat, vc; logic [31:0] oa, ow, ol; logic owe, om, ob, pok; logic [3:0] os;
    // LW aligned, zero wait
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, lat, vc, oa, owe, os, ow, ol, om, ob, pok);
    n_tests++;
    if (lat !== 2 || oa !== 32'h100 || ol !== 32'hDEADBEEF || om !== 1'b0 || !pok) begin
      n_fail++;
      $display("FAIL lw_basic got lat=%0d addr=%h ld=%h mis=%b ok=%b exp lat=2 addr=100 ld=deadbeef mis=0 ok=1", lat, oa, ol, om, pok);
    end
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, lat, vc, oa, owe, os, ow, ol, om, ob, pok);
    n_tests++;
    if (ol !== 32'hFFFFFF80 || oa !== 32'h100) begin
      n_fail++;
      $display("FAIL lb_sign got ld=%h addr=%h exp ld=ffffff80 addr=100", ol, oa);
    end
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, lat, vc, oa, owe, os, ow, ol, om, ob, pok);
    n_tests++;
    if (ol !== 32'h00000080 || lat !== 3) begin
      n_fail++;
      $display("FAIL lbu_zero got ld=%h lat=%0d exp ld=00000080 lat=3", ol, lat);
    end
    run_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FFFFFF, 0, lat, vc, oa, owe, os, ow, ol, om, ob, pok);
    n_tests++;
    if (ol !== 32'h000080FF) begin
      n_fail++;
      $display("FAIL lhu_zero got ld=%h exp ld=000080ff", ol);
    end
    run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0, lat, vc, oa, owe, os, ow, ol, om, ob, pok);
    n_tests++;
    if (os !== 4'b1100 || ow !== 32'hABCDABCD || owe !== 1'b1 || oa !== 32'h200 || ol !== 32'h0) begin
      n_fail++;
      $display("FAIL sh_lanes got wstrb=%b wdata=%h we=%b addr=%h ld=%h exp 1100 abcdabcd 1 200 0", os, ow, owe, oa, ol);
    end
    run_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, lat, vc, oa, owe, os, ow, ol, om, ob, pok);
    n_tests++;
    if (lat !== 1 || om !== 1'b1 || vc !== 0 || ob !== 1'b0 || !pok) begin
      n_fail++;
      $display("FAIL lw_misaligned got lat=%0d mis=%b valid_cycles=%0d berr=%b ok=%b exp 1 1 0 0 1", lat, om, vc, ob, pok);
    end
  endtask

  task automatic test_timeout();
    int lat, vc; logic [31:0] oa, ow, ol; logic owe, om, ob, pok; logic [3:0] os;
    run_access(1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 100, lat, vc, oa, owe, os, ow, ol, om, ob, pok);
    n_tests++;
    if (vc !== 4 || lat !== 5 || ob !== 1'b1 || om !== 1'b0 || ol !== 32'h0 || !pok) begin
      n_fail++;
      $display("FAIL timeout got valid_cycles=%0d lat=%0d berr=%b mis=%b ld=%h ok=%b exp 4 5 1 0 0 1", vc, lat, ob, om, ol, pok);
    end
  endtask

  task automatic test_rst_mid();
    int lat, vc; logic [31:0] oa, ow, ol; logic owe, om, ob, pok; logic [3:0] os;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80; mif.mem_ready = 1'b0;
    tick(); start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if (mif.mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got valid=%b busy=%b done=%b exp 0 0 0", mif.mem_valid, busy, done);
    end
    rst = 1'b0;
    tick();
    run_access(1'b0, 3'b010, 32'h84, 32'h0, 32'hCAFEF00D, 0, lat, vc, oa, owe, os, ow, ol, om, ob, pok);
    n_tests++;
    if (lat !== 2 || ol !== 32'hCAFEF00D || oa !== 32'h84) begin
      n_fail++;
      $display("FAIL rst_recover got lat=%0d ld=%h addr=%h exp 2 cafef00d 84", lat, ol, oa);
    end
  endtask

  task automatic test_start_ignored();
    // Pulse start during the REQ wait: the beat must keep its original request.
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
    mif.mem_ready = 1'b0; mif.mem_rdata = 32'h0BADC0DE;
    tick(); start = 1'b0;
    tick();
    start = 1'b1; is_store = 1'b1; addr = 32'h500; store_data = 32'hFFFFFFFF;
    tick(); start = 1'b0;
    n_tests++;
    if (mif.mem_addr !== 32'h300 || mif.mem_we !== 1'b0 || mif.mem_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore got addr=%h we=%b valid=%b exp 300 0 1", mif.mem_addr, mif.mem_we, mif.mem_valid);
    end
    mif.mem_ready = 1'b1;
    tick(); mif.mem_ready = 1'b0;
    n_tests++;
    if (done !== 1'b1 || load_data !== 32'h0BADC0DE) begin
      n_fail++;
      $display("FAIL busy_ignore_done got done=%b ld=%h exp 1 0badc0de", done, load_data);
    end
    tick(); tick();
    n_tests++;
    if (mif.mem_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_queue got valid=%b busy=%b exp 0 0", mif.mem_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    // start held high through the RESP cycle is dropped, then accepted in IDLE.
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40; mif.mem_ready = 1'b1;
    mif.mem_rdata = 32'h11223344;
    tick();
    tick();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_done got done=%b exp 1", done);
    end
    tick();
    n_tests++;
    if (mif.mem_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_resp_drop got valid=%b busy=%b exp 0 0", mif.mem_valid, busy);
    end
    tick();
    start = 1'b0;
    n_tests++;
    if (mif.mem_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_req got valid=%b busy=%b exp 1 1", mif.mem_valid, busy);
    end
    tick();
    mif.mem_ready = 1'b0;
    n_tests++;
    if (done !== 1'b1 || load_data !== 32'h11223344) begin
      n_fail++;
      $display("FAIL b2b_second_done got done=%b ld=%h exp 1 11223344", done, load_data);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, vc, w; logic [31:0] oa, ow, ol, a, sd, rd; logic owe, om, ob, pok, st, ok; logic [3:0] os;
    logic [2:0] f3;
    for (int it = 0; it < 200; it++) begin
      st = 1'(($urandom % 2));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      sd = $urandom; rd = $urandom;
      w  = int'($urandom_range(0, 3));
      ok = model_ok(st, f3, a);
      run_access(st, f3, a, sd, rd, w, lat, vc, oa, owe, os, ow, ol, om, ob, pok);
      n_tests++;
      if (!pok || ob !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_protocol it=%0d got ok=%b berr=%b exp 1 0", it, pok, ob);
      end
      if (!ok) begin
        n_tests++;
        if (lat !== 1 || om !== 1'b1 || vc !== 0) begin
          n_fail++;
          $display("FAIL rnd_fault it=%0d st=%b f3=%0d a=%h got lat=%0d mis=%b vc=%0d exp 1 1 0", it, st, f3, a, lat, om, vc);
        end
      end else begin
        n_tests++;
        if (lat !== w + 2 || vc !== w + 1 || om !== 1'b0 || oa !== {a[31:2], 2'b00} || owe !== st) begin
          n_fail++;
          $display("FAIL rnd_timing it=%0d got lat=%0d vc=%0d mis=%b addr=%h we=%b exp %0d %0d 0 %h %b",
                   it, lat, vc, om, oa, owe, w + 2, w + 1, {a[31:2], 2'b00}, st);
        end
        n_tests++;
        if (st) begin
          if (os !== model_strb(f3, a) || ow !== model_wdata(f3, sd) || ol !== 32'h0) begin
            n_fail++;
            $display("FAIL rnd_store it=%0d f3=%0d a=%h got wstrb=%b wdata=%h ld=%h exp %b %h 0",
                     it, f3, a, os, ow, ol, model_strb(f3, a), model_wdata(f3, sd));
          end
        end else begin
          if (ol !== model_load(f3, a, rd) || os !== 4'b0000) begin
            n_fail++;
            $display("FAIL rnd_load it=%0d f3=%0d a=%h rd=%h got ld=%h wstrb=%b exp %h 0000",
                     it, f3, a, rd, ol, os, model_load(f3, a, rd));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_rst_mid();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
